id_ex_ctrl_skid: RTL

//  Elastic ID->EX control pipeline register: carries the decoded ALU control bundle and its PC tag.

---
 rtl/id_ex_ctrl_skid_if.sv | 71 +++++++
 rtl/id_ex_ctrl_skid.sv | 129 ++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_skid_if.sv
// ID->EX control bundle handshake interface.
// Optional stall_cycles signal exists only with ID_EX_STALL_CNT_EN.
interface id_ex_ctrl_skid_if #(
  parameter int ALU_OP_WIDTH    = 7,
  parameter int ALU_FUNC3_WIDTH = 3,
  parameter int ALU_FUNC7_WIDTH = 7,
`ifdef ID_EX_STALL_CNT_EN
  parameter int PC_WIDTH        = 64,
  parameter int CNT_WIDTH       = 32
`else
  parameter int PC_WIDTH        = 64
`endif
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       alu_src_in;
  logic [ALU_OP_WIDTH-1:0]    alu_op_in;
  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in;
  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in;
  logic [PC_WIDTH-1:0]        pc_in;
  logic                       out_valid;
  logic                       out_ready;
  logic                       alu_src_out;
  logic [ALU_OP_WIDTH-1:0]    alu_op_out;
  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out;
  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out;
  logic [PC_WIDTH-1:0]        pc_out;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_WIDTH-1:0]       stall_cycles;
`endif

  modport master (
`ifdef ID_EX_STALL_CNT_EN
    input  stall_cycles,
`endif
    output in_valid,
    output alu_src_in,
    output alu_op_in,
    output alu_func3_in,
    output alu_func7_in,
    output pc_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  alu_src_out,
    input  alu_op_out,
    input  alu_func3_out,
    input  alu_func7_out,
    input  pc_out
  );

  modport slave (
`ifdef ID_EX_STALL_CNT_EN
    output stall_cycles,
`endif
    input  in_valid,
    input  alu_src_in,
    input  alu_op_in,
    input  alu_func3_in,
    input  alu_func7_in,
    input  pc_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output alu_src_out,
    output alu_op_out,
    output alu_func3_out,
    output alu_func7_out,
    output pc_out
  );
endinterface

// File: rtl/id_ex_ctrl_skid.sv
// Elastic ID->EX control register with 2-entry skid buffer and flush.
// Define ID_EX_STALL_CNT_EN to add the saturating stall_cycles counter.
module id_ex_ctrl_skid #(
  parameter int ALU_OP_WIDTH    = 7,
  parameter int ALU_FUNC3_WIDTH = 3,
  parameter int ALU_FUNC7_WIDTH = 7,
`ifdef ID_EX_STALL_CNT_EN
  parameter int PC_WIDTH        = 64,
  parameter int CNT_WIDTH       = 32
`else
  parameter int PC_WIDTH        = 64
`endif
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  id_ex_ctrl_skid_if.slave bus
);

  typedef struct packed {
    logic                       src;
    logic [ALU_OP_WIDTH-1:0]    op;
    logic [ALU_FUNC3_WIDTH-1:0] f3;
    logic [ALU_FUNC7_WIDTH-1:0] f7;
    logic [PC_WIDTH-1:0]        pc;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_b, out_b;
  logic    in_fire, out_fire;

  assign in_b = {bus.alu_src_in, bus.alu_op_in,
                 bus.alu_func3_in, bus.alu_func7_in,
                 bus.pc_in};

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Bubbles present all-zero control so EX sees a NOP.
  assign out_b = bus.out_valid ? main_q : '0;

  assign bus.alu_src_out   = out_b.src;
  assign bus.alu_op_out    = out_b.op;
  assign bus.alu_func3_out = out_b.f3;
  assign bus.alu_func7_out = out_b.f7;
  assign bus.pc_out        = out_b.pc;

  // Next state and entry updates; flush wins over any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_b;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            in_fire & out_fire: begin
              main_d = in_b;
            end
            in_fire & !bus.out_ready: begin
              skid_d  = in_b;
              state_d = FULL;
            end
            out_fire & !bus.in_valid: begin
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  assign bus.stall_cycles = stall_q;

  // Saturating count of cycles EX held a valid bundle back.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready
                 && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule
